cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have one clock and asynchronous active-high reset: ports clk and reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 icache_addr  input  32  I-cache line-miss address.
REQ-005 icache_read  input  1  I-cache line-fill request.
REQ-006 icache_rdata256  output  256  line data to I-cache.
REQ-007 icache_resp  output  1  I-cache transaction complete.
REQ-008 dcache_addr  input  32  D-cache line address (fill or writeback).
REQ-009 dcache_read  input  1  D-cache line-fill request.
REQ-010 dcache_write  input  1  D-cache writeback request.
REQ-011 dcache_wdata256  input  256  D-cache writeback line.
REQ-012 dcache_rdata256  output  256  line data to D-cache.
REQ-013 dcache_resp  output  1  D-cache transaction complete.
REQ-014 pmem_addr  output  32  shared memory line address, bits [4:0] forced to 0.
REQ-015 pmem_read  output  1  shared memory read strobe.
REQ-016 pmem_write  output  1  shared memory write strobe.
REQ-017 pmem_wdata256  output  256  shared memory write line.
REQ-018 pmem_rdata256  input  256  shared memory read line.
REQ-019 pmem_resp  input  1  shared memory transaction complete.

Function
REQ-020 The arbiter SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-021 In IDLE, pmem_read, pmem_write, icache_resp and dcache_resp SHALL be 0.
REQ-022 In IDLE, a D-cache request is dcache_read|dcache_write; an I-cache request is icache_read.
REQ-023 In IDLE with one request, that requester SHALL be granted at the rising edge.
REQ-024 In IDLE with both requesting, the requester not granted last SHALL win (round-robin via a 1-bit last_grant register).
REQ-025 On grant, address (low 5 bits zeroed), operation and D-cache write line SHALL be latched into registers; next state BUSY_I or BUSY_D; last_grant updated.
REQ-026 In BUSY_x, pmem_addr/pmem_read/pmem_write/pmem_wdata256 SHALL be driven only from the latched registers and held stable until pmem_resp.
REQ-027 Latency: request visible in IDLE at cycle N -> pmem strobe asserted in cycle N+1.
REQ-028 When pmem_resp=1 in BUSY_x, the granted requester's resp SHALL be 1 combinationally in that cycle, and the next state SHALL be IDLE.
REQ-029 icache_rdata256 and dcache_rdata256 SHALL both equal pmem_rdata256 combinationally; only resp qualifies them.
REQ-030 The non-granted requester's resp SHALL remain 0 for the whole transaction.
REQ-031 pmem_resp while in IDLE SHALL be ignored.
REQ-032 dcache_read and dcache_write both set in IDLE: write SHALL take precedence and read is ignored.
REQ-033 Request changes while in BUSY_x SHALL be ignored; requesters hold requests until resp and drop them the cycle after resp.
REQ-034 A requester still asserting in the IDLE cycle after its resp SHALL be treated as a new request.
REQ-035 Back-to-back transactions SHALL have exactly one IDLE cycle between pmem_resp and the next pmem strobe.

Reset
REQ-036 Reset SHALL force state IDLE, pmem_read=0, pmem_write=0, both resp=0, latched address/data=0, last_grant=D-cache (first tie goes to I-cache).
REQ-037 Reset mid-transaction SHALL drop pmem strobes asynchronously with no resp generated; the aborted request is not retried.

Structure
REQ-038 The state enum (IDLE, BUSY_I, BUSY_D) and grant enum (GRANT_I, GRANT_D) SHALL be in shared package cache_arbiter_types.
REQ-039 The block SHALL be a single module with no sub-modules; next-state/output logic combinational, state/latches in one async-reset sequential process.

Verification
REQ-040 I-only: icache_read=1, addr 0x0000_1234 -> next cycle pmem_read=1, pmem_addr=0x0000_1220; pmem_resp with data 0xAA..AA -> icache_resp=1 same cycle, icache_rdata256=0xAA..AA, dcache_resp=0.
REQ-041 Tie: both read at reset exit -> I granted first; both re-request after completion -> D granted; third tie -> I.
REQ-042 Writeback: dcache_write=1, addr 0x8000_0040, wdata 0x55..55 -> pmem_write=1, pmem_wdata256=0x55..55 stable for a 10-cycle memory latency; dcache_resp on cycle of pmem_resp.
REQ-043 Read+write from D together -> pmem_write=1, pmem_read=0.
REQ-044 Spurious pmem_resp in IDLE -> no resp to either cache; changing icache_addr during BUSY_I -> pmem_addr unchanged.
REQ-045 Reset asserted during BUSY_D -> pmem_write falls without a clock edge, no dcache_resp; after release, a pending I request is granted.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_types: shared FSM/grant enums and line-address constants for the cache arbiter.
package cache_arbiter_types;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFE0;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one line-wide memory port between I-cache and D-cache.
module cache_arbiter
  import cache_arbiter_types::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_read,
  output logic [LINE_W-1:0] icache_rdata256,
  output logic              icache_resp,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [LINE_W-1:0] dcache_wdata256,
  output logic [LINE_W-1:0] dcache_rdata256,
  output logic              dcache_resp,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [LINE_W-1:0] pmem_wdata256,
  input  logic [LINE_W-1:0] pmem_rdata256,
  input  logic              pmem_resp
);
  state_t            state, next_state;
  grant_t            last_grant, grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              d_req;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state != IDLE) begin
        last_grant <= grant;
        addr_q     <= (grant == GRANT_D ? dcache_addr : icache_addr) & LINE_MASK;
        write_q    <= (grant == GRANT_D) & dcache_write;
        wdata_q    <= dcache_wdata256;
      end
    end
  end
  // On a tie the side that did not win last time gets the port.
  always_comb begin
    d_req      = dcache_read | dcache_write;
    grant      = (icache_read & d_req) ? (last_grant == GRANT_D ? GRANT_I : GRANT_D)
                                       : (d_req ? GRANT_D : GRANT_I);
    next_state = (state == IDLE) ? ((icache_read | d_req) ? (grant == GRANT_D ? BUSY_D : BUSY_I) : IDLE)
                                 : (pmem_resp ? IDLE : state);
  end
  always_comb begin
    pmem_addr       = addr_q;
    pmem_wdata256   = wdata_q;
    pmem_read       = (state != IDLE) & ~write_q;
    pmem_write      = (state != IDLE) & write_q;
    icache_resp     = (state == BUSY_I) & pmem_resp;
    dcache_resp     = (state == BUSY_D) & pmem_resp;
    icache_rdata256 = pmem_rdata256;
    dcache_rdata256 = pmem_rdata256;
  end
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench; directed stimulus queues expected memory transactions and cache responses.
module tb_cache_arbiter;
  logic         clk = 0, reset = 1;
  logic [31:0]  icache_addr = '0, dcache_addr = '0, pmem_addr;
  logic         icache_read = 0, dcache_read = 0, dcache_write = 0, pmem_resp = 0;
  logic [255:0] dcache_wdata256 = '0, pmem_rdata256 = '0;
  logic [255:0] icache_rdata256, dcache_rdata256, pmem_wdata256;
  logic         icache_resp, dcache_resp, pmem_read, pmem_write;
  typedef struct {logic [31:0] addr; logic wr; logic [255:0] wdata;} mem_t;
  typedef struct {logic is_d; logic [255:0] data;} resp_t;
  mem_t  exp_mem[$];
  resp_t exp_resp[$];
  mem_t  cur;
  resp_t r;
  logic  in_txn = 0;
  int    checks = 0, errors = 0;
  cache_arbiter dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_read(icache_read),
    .icache_rdata256(icache_rdata256), .icache_resp(icache_resp),
    .dcache_addr(dcache_addr), .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_wdata256(dcache_wdata256), .dcache_rdata256(dcache_rdata256), .dcache_resp(dcache_resp),
    .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata256(pmem_wdata256), .pmem_rdata256(pmem_rdata256), .pmem_resp(pmem_resp)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_mem(input logic [31:0] a, input logic wr, input logic [255:0] wd);
    exp_mem.push_back('{a, wr, wd});
  endtask
  task automatic push_resp(input logic is_d, input logic [255:0] d);
    exp_resp.push_back('{is_d, d});
  endtask
  task automatic granted(input string name, input logic wr);
    @(posedge clk); #1;
    chk(name, {pmem_read, pmem_write}, wr ? 2'b01 : 2'b10);
  endtask
  task automatic serve(input int lat, input logic [255:0] d);
    repeat (lat - 1) begin @(posedge clk); #1; end
    pmem_resp = 1; pmem_rdata256 = d;
    @(posedge clk); #1;
    pmem_resp = 0;
  endtask
  always @(negedge clk) begin
    if (reset) in_txn = 0;
    else begin
      if (icache_resp | dcache_resp) begin
        if (exp_resp.size() == 0) chk("spurious_resp", {icache_resp, dcache_resp}, 0);
        else begin
          r = exp_resp.pop_front();
          chk("resp_sel", {icache_resp, dcache_resp}, r.is_d ? 2'b01 : 2'b10);
          chk("resp_data", r.is_d ? dcache_rdata256 : icache_rdata256, r.data);
        end
      end
      if (pmem_read | pmem_write) begin
        if (!in_txn) begin
          if (exp_mem.size() == 0) chk("spurious_strobe", {pmem_read, pmem_write}, 0);
          else cur = exp_mem.pop_front();
          in_txn = 1;
        end
        chk("pmem_addr", pmem_addr, cur.addr);
        chk("pmem_op", {pmem_read, pmem_write}, cur.wr ? 2'b01 : 2'b10);
        if (cur.wr) chk("pmem_wdata", pmem_wdata256, cur.wdata);
      end else in_txn = 0;
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    #12;
    chk("rst_strobes", {pmem_read, pmem_write}, 0);
    chk("rst_resp", {icache_resp, dcache_resp}, 0);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_wdata", pmem_wdata256, 0);
    @(posedge clk); #1;
    reset = 0;
    // three ties in a row: I, D, I
    icache_addr = 32'h0000_0100; dcache_addr = 32'h0000_0200;
    icache_read = 1; dcache_read = 1;
    push_mem(32'h0000_0100, 0, '0); push_resp(0, {8{32'h1111_1111}});
    push_mem(32'h0000_0200, 0, '0); push_resp(1, {8{32'h2222_2222}});
    push_mem(32'h0000_0100, 0, '0); push_resp(0, {8{32'h3333_3333}});
    granted("tie1_grant", 0);
    serve(1, {8{32'h1111_1111}});
    granted("tie2_grant", 0);
    serve(2, {8{32'h2222_2222}});
    granted("tie3_grant", 0);
    serve(1, {8{32'h3333_3333}});
    icache_read = 0; dcache_read = 0;
    // I-only read; address changes mid-transaction must not reach pmem
    icache_addr = 32'h0000_1234; icache_read = 1;
    push_mem(32'h0000_1220, 0, '0); push_resp(0, {8{32'hAAAA_AAAA}});
    granted("i_only_grant", 0);
    icache_addr = 32'hFFFF_FFFF;
    serve(3, {8{32'hAAAA_AAAA}});
    icache_read = 0;
    // spurious memory response while idle
    @(posedge clk); #1;
    pmem_resp = 1; pmem_rdata256 = {8{32'h0BAD_0BAD}};
    #4;
    chk("idle_spurious_resp", {icache_resp, dcache_resp}, 0);
    chk("idle_spurious_strobe", {pmem_read, pmem_write}, 0);
    @(posedge clk); #1;
    pmem_resp = 0;
    chk("idle_after_spurious", {pmem_read, pmem_write}, 0);
    // writeback with 10-cycle memory latency
    dcache_addr = 32'h8000_0040; dcache_write = 1; dcache_wdata256 = {8{32'h5555_5555}};
    push_mem(32'h8000_0040, 1, {8{32'h5555_5555}}); push_resp(1, {8{32'hCAFE_F00D}});
    granted("wb_grant", 1);
    dcache_wdata256 = '0;
    serve(10, {8{32'hCAFE_F00D}});
    dcache_write = 0;
    // simultaneous D read and write: write wins
    dcache_addr = 32'h0000_0ABC; dcache_read = 1; dcache_write = 1;
    dcache_wdata256 = {8{32'h1234_5678}};
    push_mem(32'h0000_0AA0, 1, {8{32'h1234_5678}}); push_resp(1, {8{32'h7777_7777}});
    granted("rw_write_wins", 1);
    serve(3, {8{32'h7777_7777}});
    dcache_read = 0; dcache_write = 0;
    // reset mid-writeback, then a pending I request
    dcache_addr = 32'h0000_0040; dcache_write = 1; dcache_wdata256 = {8{32'hDEAD_BEEF}};
    push_mem(32'h0000_0040, 1, {8{32'hDEAD_BEEF}});
    granted("abort_grant", 1);
    @(posedge clk); #3;
    reset = 1; icache_addr = 32'h0000_3000; icache_read = 1;
    #1;
    chk("abort_async_strobe", {pmem_read, pmem_write}, 0);
    chk("abort_no_resp", {icache_resp, dcache_resp}, 0);
    chk("abort_addr_cleared", pmem_addr, 0);
    dcache_write = 0;
    @(posedge clk); #1;
    reset = 0;
    push_mem(32'h0000_3000, 0, '0); push_resp(0, {8{32'h4444_4444}});
    granted("post_reset_i_grant", 0);
    serve(2, {8{32'h4444_4444}});
    icache_read = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("exp_mem_drained", exp_mem.size(), 0);
    chk("exp_resp_drained", exp_resp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
